// File: rtl/lane_mon_pkg.sv
// Shared lane geometry and the event record passed from the arbiter into the event queue.
package lane_mon_pkg;
  localparam int LANES      = 4;
  localparam int LANE_W     = 8;
  localparam int LANE_IDX_W = $clog2(LANES);

  typedef struct packed {
    logic [LANE_IDX_W-1:0] lane;
    logic [LANE_W-1:0]     value;
  } lane_evt_t;
endpackage

// File: rtl/lane_evt_fifo.sv
// Synchronous show-ahead event queue; head is the oldest entry whenever empty is low.
module lane_evt_fifo
  import lane_mon_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  lane_evt_t din,
  output logic      full,
  output logic      empty,
  output lane_evt_t head
);
  localparam int AW = $clog2(DEPTH);

  lane_evt_t      mem [DEPTH];
  logic [AW:0]    wptr, rptr;

  // Extra pointer bit distinguishes full from empty when the indices match.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wptr[AW-1:0]] <= din;
        wptr              <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
    end
  end

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign head  = mem[rptr[AW-1:0]];
endmodule

// File: rtl/lane_change_monitor.sv
// Per-lane debounce of an asynchronous packed bus; settled changes are counted and queued as events.
// Lane geometry (LANES, LANE_W) comes from lane_mon_pkg.
module lane_change_monitor
  import lane_mon_pkg::*;
#(
  parameter int STABLE_CYC = 3,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LANES*LANE_W-1:0] data_in,
  input  logic                    clr_cnt,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [LANE_IDX_W-1:0]   evt_lane,
  output logic [LANE_W-1:0]       evt_value,
  output logic                    evt_overflow,
  output logic [LANES*CNT_W-1:0]  chg_cnt,
  output logic                    busy
);
  localparam int             SW       = $clog2(STABLE_CYC + 1);
  localparam logic [SW-1:0]  STAB_MAX = SW'(STABLE_CYC);

  logic [LANES-1:0][LANE_W-1:0] sync0, sync1, cand, acc;
  logic [LANES-1:0][CNT_W-1:0]  cnt;
  logic [LANES-1:0]             commit_req, grant, diff;
  logic                         commit, found, push, pop, full, empty, ovf;
  lane_evt_t                    evt_in, head;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync0 <= '0;
      sync1 <= '0;
    end else begin
      sync0 <= data_in;
      sync1 <= sync0;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [LANE_W-1:0] cand_q, acc_q;
    logic [SW-1:0]     stab_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        cand_q <= '0;
        acc_q  <= '0;
        stab_q <= '0;
      end else begin
        if (sync1[i] != cand_q) begin
          cand_q <= sync1[i];
          stab_q <= '0;
        end else if (stab_q != STAB_MAX) begin
          stab_q <= stab_q + 1'b1;
        end
        if (grant[i]) acc_q <= cand_q;
      end
    end

    assign cand[i]       = cand_q;
    assign acc[i]        = acc_q;
    assign diff[i]       = (cand_q != acc_q);
    assign commit_req[i] = (stab_q == STAB_MAX) && diff[i];
  end

  // Fixed priority: lowest requesting lane commits, the rest retry next cycle.
  always_comb begin
    grant  = '0;
    found  = 1'b0;
    evt_in = '0;
    for (int i = 0; i < LANES; i++) begin
      if (commit_req[i] && !found) begin
        grant[i]     = 1'b1;
        found        = 1'b1;
        evt_in.lane  = LANE_IDX_W'(i);
        evt_in.value = cand[i];
      end
    end
  end

  assign commit = |commit_req;
  assign pop    = !empty && evt_ready;
  assign push   = commit && (!full || pop);

  lane_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (evt_in),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      for (int i = 0; i < LANES; i++)
        if (grant[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + 1'b1;
      if (commit && full && !pop) ovf <= 1'b1;
    end
  end

  assign evt_valid    = !empty;
  assign evt_lane     = empty ? '0 : head.lane;
  assign evt_value    = empty ? '0 : head.value;
  assign evt_overflow = ovf;
  assign chg_cnt      = cnt;
  assign busy         = !empty || (|diff);
endmodule

// File: tb/tb_lane_change_monitor.sv
// Directed bench for lane_change_monitor with hand-computed expectations.
module tb_lane_change_monitor;
  import lane_mon_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [31:0]           data_in = '0;
  logic                  clr_cnt = 1'b0;
  logic                  evt_valid;
  logic                  evt_ready = 1'b0;
  logic [LANE_IDX_W-1:0] evt_lane;
  logic [LANE_W-1:0]     evt_value;
  logic                  evt_overflow;
  logic [63:0]           chg_cnt;
  logic                  busy;

  int n_chk  = 0;
  int n_fail = 0;

  lane_change_monitor #(.STABLE_CYC(3), .FIFO_DEPTH(8), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .clr_cnt      (clr_cnt),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_lane     (evt_lane),
    .evt_value    (evt_value),
    .evt_overflow (evt_overflow),
    .chg_cnt      (chg_cnt),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] exp_v4 [4];
  logic [7:0] exp_v6 [4];

  initial begin
    exp_v4[0] = 8'h11; exp_v4[1] = 8'h22; exp_v4[2] = 8'h33; exp_v4[3] = 8'h44;
    exp_v6[0] = 8'h77; exp_v6[1] = 8'h66; exp_v6[2] = 8'h55; exp_v6[3] = 8'h44;

    // 1: reset, idle bus
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_valid", 64'(evt_valid), 64'd0);
    chk("rst_lane", 64'(evt_lane), 64'd0);
    chk("rst_value", 64'(evt_value), 64'd0);
    chk("rst_ovf", 64'(evt_overflow), 64'd0);
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("idle_valid", 64'(evt_valid), 64'd0);
      chk("idle_cnt", chg_cnt, 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);
    end

    // 2: single-lane step, event visible after the 7th edge
    evt_ready = 1'b1;
    data_in   = 32'h0000_00A5;
    for (int c = 1; c <= 6; c++) begin
      tick();
      chk("lat_valid_lo", 64'(evt_valid), 64'd0);
    end
    tick();
    chk("lat_valid_hi", 64'(evt_valid), 64'd1);
    chk("t2_lane", 64'(evt_lane), 64'd0);
    chk("t2_value", 64'(evt_value), 64'hA5);
    chk("t2_cnt", chg_cnt, 64'd1);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t2_single", 64'(evt_valid), 64'd0);
    end
    chk("t2_busy", 64'(busy), 64'd0);

    // 3: glitch on lane1 shorter than the debounce window
    data_in = 32'h0000_11A5;
    tick();
    tick();
    data_in = 32'h0000_00A5;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("t3_noevt", 64'(evt_valid), 64'd0);
    end
    chk("t3_cnt", chg_cnt, 64'd1);
    chk("t3_busy", 64'(busy), 64'd0);

    // back to zero (lane0 change to 00), then clear counts
    data_in = 32'h0;
    repeat (10) tick();
    chk("t4pre_cnt", chg_cnt, 64'd2);
    chk("t4pre_valid", 64'(evt_valid), 64'd0);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("t4pre_clr", chg_cnt, 64'd0);

    // 4: all lanes change together -> four back-to-back events
    data_in = 32'h4433_2211;
    repeat (6) tick();
    chk("t4_valid_lo", 64'(evt_valid), 64'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t4_valid", 64'(evt_valid), 64'd1);
      chk("t4_lane", 64'(evt_lane), 64'(k));
      chk("t4_value", 64'(evt_value), 64'(exp_v4[k]));
    end
    tick();
    chk("t4_drained", 64'(evt_valid), 64'd0);
    chk("t4_cnt", chg_cnt, 64'h0001_0001_0001_0001);

    // 5: ten changes on lane0 with the reader stalled
    evt_ready = 1'b0;
    clr_cnt   = 1'b1;
    tick();
    clr_cnt   = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      data_in = {24'h443322, 8'(k)};
      repeat (8) tick();
      if (k == 8) begin
        chk("t5_ovf_lo", 64'(evt_overflow), 64'd0);
        chk("t5_cnt8", chg_cnt, 64'd8);
      end
      if (k == 9) chk("t5_ovf_hi", 64'(evt_overflow), 64'd1);
    end
    chk("t5_cnt10", chg_cnt, 64'd10);
    chk("t5_hold_value", 64'(evt_value), 64'h01);
    evt_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      chk("t5_drain_valid", 64'(evt_valid), 64'd1);
      chk("t5_drain_lane", 64'(evt_lane), 64'd0);
      chk("t5_drain_value", 64'(evt_value), 64'(k));
      tick();
    end
    chk("t5_empty", 64'(evt_valid), 64'd0);
    chk("t5_ovf_sticky", 64'(evt_overflow), 64'd1);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("t5_clr_cnt", chg_cnt, 64'd0);
    chk("t5_clr_ovf", 64'(evt_overflow), 64'd0);

    // 6: reset with three events queued, then re-commit from acc=0
    evt_ready = 1'b0;
    data_in   = 32'h4455_6677;
    repeat (12) tick();
    chk("t6_pre_valid", 64'(evt_valid), 64'd1);
    chk("t6_pre_value", 64'(evt_value), 64'h77);
    chk("t6_pre_cnt", chg_cnt, 64'h0000_0001_0001_0001);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_valid", 64'(evt_valid), 64'd0);
    chk("t6_rst_cnt", chg_cnt, 64'd0);
    chk("t6_rst_ovf", 64'(evt_overflow), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    evt_ready = 1'b1;
    repeat (6) tick();
    chk("t6_valid_lo", 64'(evt_valid), 64'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t6_valid", 64'(evt_valid), 64'd1);
      chk("t6_lane", 64'(evt_lane), 64'(k));
      chk("t6_value", 64'(evt_value), 64'(exp_v6[k]));
    end
    tick();
    chk("t6_drained", 64'(evt_valid), 64'd0);
    chk("t6_cnt", chg_cnt, 64'h0001_0001_0001_0001);
    chk("t6_busy", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
